// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the memory-copy DMA: FSM state encoding and default widths.
// Imported by mem_copy_dma, copy_addr_gen, the top-level port mux and the bench.
package mem_copy_dma_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_dma_addr_gen.sv
// copy_addr_gen: source/destination word pointers and remaining-word counter.
// Ports: clk, rst (async active-low); load captures src/dst/len; step_src bumps the
// source pointer; step_dst bumps the destination pointer and consumes one word;
// last flags the final word (remaining == 1). Pointers wrap modulo 2^AW.
module copy_addr_gen
    import mem_copy_dma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step_src,
    input  logic          step_dst,
    input  logic [AW-1:0] src_in,
    input  logic [AW-1:0] dst_in,
    input  logic [LW-1:0] len_in,
    output logic [AW-1:0] src_ptr,
    output logic [AW-1:0] dst_ptr,
    output logic          last
);

    logic [LW-1:0] remaining;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else if (load) begin
            src_ptr   <= src_in;
            dst_ptr   <= dst_in;
            remaining <= len_in;
        end else begin
            if (step_src) begin
                src_ptr <= src_ptr + AW'(1);
            end
            if (step_dst) begin
                dst_ptr   <= dst_ptr + AW'(1);
                remaining <= remaining - LW'(1);
            end
        end
    end

    assign last = (remaining == LW'(1));

endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator copying len words from src_addr to dst_addr, one
// read/write cycle pair per word, ascending, with wrap-around pointers.
// Ports: clk, rst (async active-low), start/src_addr/dst_addr/len request,
// busy/done status, mem_addr/mem_wdata/mem_we/mem_re/mem_rdata memory port,
// checksum (only when MEM_COPY_CHECKSUM_EN is defined: mod-2^DW sum of copied words).
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          step_src;
    logic          step_dst;
    logic          last;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [DW-1:0] data_reg;

    copy_addr_gen #(
        .AW(AW),
        .LW(LW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step_src(step_src),
        .step_dst(step_dst),
        .src_in  (src_addr),
        .dst_in  (dst_addr),
        .len_in  (len),
        .src_ptr (src_ptr),
        .dst_ptr (dst_ptr),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_src  = 1'b0;
        step_dst  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    // a zero-length request skips the memory port entirely
                    state_nxt = (len != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                step_src  = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                step_dst  = 1'b1;
                state_nxt = last ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (state == S_READ) begin
            data_reg <= mem_rdata;
        end
    end

    // Port outputs decode the state register only, so mem_rdata never
    // reaches an output combinationally and reset clears them at once.
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_re    = (state == S_READ);
    assign mem_we    = (state == S_WRITE);
    assign mem_wdata = (state == S_WRITE) ? data_reg : '0;
    assign mem_addr  = (state == S_READ)  ? src_ptr :
                       (state == S_WRITE) ? dst_ptr : '0;

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (state == S_WRITE) begin
            checksum <= checksum + data_reg;
        end
    end
`else
    // no checksum accumulator in this build
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: 64K-word memory model driven by the DUT,
// reference copy computed word by word from the request, per-cycle port checks.
module tb_mem_copy_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_sum;
    int          n_checks;
    int          n_fail;
    int          done_cnt;

    mem_copy_dma dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_port(input string tag);
        check({tag, "_re"},    {31'd0, mem_re}, 32'd0);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"},  {16'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    endtask

    task automatic check_sum(input string tag);
`ifdef MEM_COPY_CHECKSUM_EN
        check(tag, {16'd0, checksum}, {16'd0, exp_sum});
`else
        check(tag, 32'd0, 32'd0 & {16'd0, exp_sum});
`endif
    endtask

    // One request. mid: re-pulse start (src=0,dst=20,len=2) during cycle 2.
    // abort_k: pull reset asynchronously during that cycle and stop.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input bit mid, input int abort_k);
        int          d0;
        int          total;
        logic [15:0] w;
        logic [15:0] i;
        d0    = done_cnt;
        total = 2 * int'(l) + 1;
        w     = '0;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        @(posedge clk);
        #1 start = 1'b0;
        exp_sum = '0;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (mid && k == 2) begin
                start    = 1'b1;
                src_addr = 16'd0;
                dst_addr = 16'd20;
                len      = 16'd2;
            end
            if (mid && k == 3) start = 1'b0;
            i = 16'((k - 1) / 2);
            check("busy", {31'd0, busy}, 32'd1);
            if (k == total) begin
                check("done", {31'd0, done}, 32'd1);
                check_idle_port("donecyc");
            end else begin
                check("done_lo", {31'd0, done}, 32'd0);
                if (k % 2 == 1) begin
                    w = ref_mem[s + i];
                    check("rd_re",   {31'd0, mem_re}, 32'd1);
                    check("rd_we",   {31'd0, mem_we}, 32'd0);
                    check("rd_addr", {16'd0, mem_addr}, {16'd0, s + i});
                    check("rd_wdat", {16'd0, mem_wdata}, 32'd0);
                end else begin
                    check("wr_we",   {31'd0, mem_we}, 32'd1);
                    check("wr_re",   {31'd0, mem_re}, 32'd0);
                    check("wr_addr", {16'd0, mem_addr}, {16'd0, d + i});
                    check("wr_data", {16'd0, mem_wdata}, {16'd0, w});
                    if (k != abort_k) begin
                        ref_mem[d + i] = w;
                        exp_sum = exp_sum + w;
                    end
                end
            end
            if (k == abort_k) begin
                #2 rst = 1'b0;
                #1;
                exp_sum = '0;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check_idle_port("abort");
                check_sum("abort_sum");
                #1 rst = 1'b1;
                @(negedge clk);
                check("abort_nodone", done_cnt - d0, 32'd0);
                return;
            end
        end
        @(negedge clk);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_end", {31'd0, done}, 32'd0);
        check_idle_port("idle");
        check("done_pulses", done_cnt - d0, 32'd1);
        check_sum("checksum");
    endtask

    task automatic check_image();
        int bad;
        bad = 0;
        for (int a = 0; a < 65536; a++) begin
            if (mem[a] !== ref_mem[a]) bad++;
        end
        check("mem_image", bad, 32'd0);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        exp_sum  = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[1] = 16'h0023;
        mem[2] = 16'h0009;
        mem[3] = 16'h0031;
        for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_idle_port("rst");
        check_sum("rst_sum");
        rst = 1'b1;

        run_copy(16'd1, 16'd16, 16'd3, 1'b0, 0);
        check("m16", {16'd0, mem[16]}, 32'h0023);
        check("m17", {16'd0, mem[17]}, 32'h0009);
        check("m18", {16'd0, mem[18]}, 32'h0031);
        check("sum_5d", {16'd0, exp_sum}, 32'h005D);

        run_copy(16'd5, 16'd9, 16'd0, 1'b0, 0);
        run_copy(16'd100, 16'd200, 16'd3, 1'b1, 0);
        run_copy(16'd300, 16'd400, 16'd4, 1'b0, 4);
        check_image();
        run_copy(16'd300, 16'd400, 16'd4, 1'b0, 0);
        run_copy(16'hFFFF, 16'h0002, 16'd2, 1'b0, 0);
        check("wrap_m2", {16'd0, mem[2]}, {16'd0, ref_mem[16'hFFFF]});
        run_copy(16'd500, 16'd502, 16'd6, 1'b0, 0);
        for (int t = 0; t < 12; t++) begin
            run_copy(16'($urandom), 16'($urandom),
                     16'($urandom_range(0, 10)), 1'b0, 0);
        end
        check_image();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
